// File: rtl/max_pool.sv
// max_pool: streaming max-pool over an HWC feature map, one window element read per cycle
// and one write per output sample, with optional ReLU on the pooled value.
module max_pool #(
  parameter int DATA_WIDTH    = 16,
  parameter int IN_ADR_WIDTH  = 16,
  parameter int OUT_ADR_WIDTH = 16,
  parameter int IN_WIDTH      = 26,
  parameter int IN_HEIGHT     = 26,
  parameter int CHANNEL       = 8,
  parameter int POOL          = 2,
  parameter int RELU_EN       = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     done,
  output logic [IN_ADR_WIDTH-1:0]  out_adrIn,
  input  logic [DATA_WIDTH-1:0]    in_dataIn,
  output logic [OUT_ADR_WIDTH-1:0] out_adrOut,
  output logic [DATA_WIDTH-1:0]    out_dataOut,
  output logic                     out_wr
);
  localparam int OUT_W = IN_WIDTH / POOL;
  localparam int OUT_H = IN_HEIGHT / POOL;
  localparam int YW = $clog2(OUT_H > 1 ? OUT_H : 2);
  localparam int XW = $clog2(OUT_W > 1 ? OUT_W : 2);
  localparam int CW = $clog2(CHANNEL > 1 ? CHANNEL : 2);
  localparam int PW = $clog2(POOL);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2;

  logic [1:0] state;
  logic [YW-1:0] oy;
  logic [XW-1:0] ox;
  logic [CW-1:0] ch;
  logic [PW-1:0] py, px;
  logic signed [DATA_WIDTH-1:0] maxReg;
  logic pxLast, pyLast, chLast, oxLast, oyLast, firstElem;

  assign pxLast    = px == PW'(POOL - 1);
  assign pyLast    = py == PW'(POOL - 1);
  assign chLast    = ch == CW'(CHANNEL - 1);
  assign oxLast    = ox == XW'(OUT_W - 1);
  assign oyLast    = oy == YW'(OUT_H - 1);
  assign firstElem = px == '0 && py == '0;

  assign done        = state == IDLE;
  assign out_wr      = state == WRITE;
  assign out_dataOut = (RELU_EN != 0 && maxReg < 0) ? '0 : maxReg;
  assign out_adrIn   = IN_ADR_WIDTH'(((32'(oy) * POOL + 32'(py)) * IN_WIDTH
                       + 32'(ox) * POOL + 32'(px)) * CHANNEL + 32'(ch));
  assign out_adrOut  = OUT_ADR_WIDTH'((32'(oy) * OUT_W + 32'(ox)) * CHANNEL + 32'(ch));

  // Counters return to zero on the final write, so IDLE always sees them cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      oy     <= '0;
      ox     <= '0;
      ch     <= '0;
      py     <= '0;
      px     <= '0;
      maxReg <= '0;
    end else begin
      case (state)
        IDLE: state <= start ? READ : IDLE;
        READ: begin
          maxReg <= (firstElem || $signed(in_dataIn) > maxReg) ? $signed(in_dataIn) : maxReg;
          px     <= pxLast ? '0 : px + 1'b1;
          if (pxLast) py <= pyLast ? '0 : py + 1'b1;
          if (pxLast && pyLast) state <= WRITE;
        end
        WRITE: begin
          ch <= chLast ? '0 : ch + 1'b1;
          if (chLast) ox <= oxLast ? '0 : ox + 1'b1;
          if (chLast && oxLast) oy <= oyLast ? '0 : oy + 1'b1;
          state <= (chLast && oxLast && oyLast) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
